// File: rtl/i2c_scl_gen.sv
// I2C bit-clock generator: SCL, a quarter-phase-leading reference clock and four phase strobes.
// Optional macro I2C_SCL_STRETCH_EN lets a low bus SCL hold the SCL-high phase (slave clock stretch).
module i2c_scl_gen #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_scl_in,
  output logic             o_scl_out,
  output logic             o_ref_out,
  output logic             o_fall_stb,
  output logic             o_change_stb,
  output logic             o_rise_stb,
  output logic             o_sample_stb,
  output logic             o_busy,
  output logic             o_stretching
);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_t;

  state_t           r_state;
  phase_t           r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic             r_stretching;

  logic [CNT_W-1:0] w_div_eff;
  logic             w_last;
  logic             w_hold;
  logic             w_run;
  logic             w_cnt0;

  assign w_div_eff = (i_div == '0) ? CNT_W'(1) : i_div;
  assign w_last    = (r_cnt == r_div_q - CNT_W'(1));

`ifdef I2C_SCL_STRETCH_EN
  // A slave pulling SCL low during the high phase freezes both counter and phase.
  assign w_hold = (r_phase == P2) && !i_scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = i_scl_in;
  assign w_hold       = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_phase      <= P0;
      r_cnt        <= '0;
      r_div_q      <= CNT_W'(1);
      r_stretching <= 1'b0;
    end else begin
      r_stretching <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_state <= S_RUN;
            r_phase <= P0;
            r_cnt   <= '0;
            r_div_q <= w_div_eff;
          end
        end
        S_RUN: begin
          if (w_hold) begin
            r_stretching <= 1'b1;
          end else if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (r_phase != P3) begin
              r_phase <= phase_t'(r_phase + 2'd1);
            end else if (i_en) begin
              // Divisor is only reloaded on a period boundary.
              r_phase <= P0;
              r_div_q <= w_div_eff;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_run  = (r_state == S_RUN);
  assign w_cnt0 = (r_cnt == '0);

  assign o_scl_out    = !w_run || r_phase[1];
  assign o_ref_out    = w_run && ((r_phase == P1) || (r_phase == P2));
  assign o_fall_stb   = w_run && (r_phase == P0) && w_cnt0;
  assign o_change_stb = w_run && (r_phase == P1) && w_cnt0;
  // cnt stays 0 through a stretch that starts on P2 entry; suppress the repeat.
  assign o_rise_stb   = w_run && (r_phase == P2) && w_cnt0 && !r_stretching;
  assign o_sample_stb = w_run && (r_phase == P3) && w_cnt0;
  assign o_busy       = w_run;
  assign o_stretching = r_stretching;

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised I2C bit-clock generator. It derives the SCL waveform and a quarter-phase-leading reference clock from the system clock, using a divisor programmable at run time. It also emits single-cycle phase strobes (SCL fall, mid-low data-change point, SCL rise, mid-high sample point) for the I2C master's bit-level FSM. Optional slave clock-stretch support holds the SCL-high phase while the bus line is held low.

## Interface
- `CNT_W`, default 8: width of the divisor and of the internal tick counter.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: run request. Sampled in IDLE to start. Sampled at the end of each period to continue.
- `div`  in  CNT_W: quarter-period length in clk cycles. Value 0 is treated as 1.
- `scl_in`  in  1: bus SCL level, already synchronised upstream. Used only with stretch enabled.
- `scl_out`  out  1: generated SCL (1 = released/high).
- `ref_out`  out  1: reference clock, leading `scl_out` by one quarter period.
- `fall_stb`  out  1: one-cycle pulse, SCL falling.
- `change_stb`  out  1: one-cycle pulse, middle of SCL low (data-change point).
- `rise_stb`  out  1: one-cycle pulse, SCL rising.
- `sample_stb`  out  1: one-cycle pulse, middle of SCL high (sample point).
- `busy`  out  1: high while in RUN.
- `stretching`  out  1: high while a clock stretch holds the counter.

## Operation
- States:
  - IDLE: `scl_out`=1, `ref_out`=0, all strobes 0, `busy`=0.
  - RUN: 2-bit phase P0..P3 plus tick counter `cnt`.
- Phase encoding (`scl_out`/`ref_out`): P0 = 0/0, P1 = 0/1, P2 = 1/1, P3 = 1/0.
- All outputs decode registered state only. There is no combinational path from any input to any output.
- IDLE→RUN: when `en`=1 is sampled. At that edge: phase←P0, `cnt`←0, `div_q`←max(`div`,1).
- In RUN:
  - `cnt` increments each cycle.
  - When `cnt`==`div_q`−1: `cnt`←0 and phase advances.
  - Each phase lasts exactly `div_q` cycles, so one SCL period is 4·`div_q` cycles.
- End of P3 (`cnt`==`div_q`−1):
  - If `en`=1: go to P0 and reload `div_q` from `div`.
  - Else: go to IDLE. A period is never truncated.
- Divisor changes take effect only at the reload points (IDLE→RUN, P3→P0). Mid-period changes are ignored for the rest of that period.
- Strobes, each asserted only while `cnt`==0:
  - `fall_stb` in P0.
  - `change_stb` in P1.
  - `rise_stb` in P2.
  - `sample_stb` in P3.
- With `div_q`=1, every strobe is high for exactly one cycle per period.
- `en` deasserted mid-period: no effect until the end of P3.
- Reset while in RUN: IDLE is entered on the next edge regardless of phase.
- Counter arithmetic is CNT_W bits unsigned. `cnt` never exceeds `div_q`−1, so it cannot wrap.

## Timing
- Reset values: `scl_out`=1, `ref_out`=0, all strobes 0, `busy`=0, `stretching`=0, `cnt`=0, `div_q`=1.
- Start latency: `en` sampled high at edge N, then `scl_out` falls, `fall_stb` asserts and `busy` rises in the cycle after edge N.
- Stop: `busy` falls in the cycle after the final P3 cycle, and `scl_out` stays 1 from then on.
- Max divisor 2^CNT_W−1 gives a period of 4·(2^CNT_W−1) cycles.

## Configuration
- Macro `I2C_SCL_STRETCH_EN`.
- Defined:
  - In P2, while `scl_in`=0, `cnt` and phase hold and `stretching`=1.
  - Counting resumes on the first cycle `scl_in` is sampled 1.
  - `rise_stb` fires once, on entry to P2, and does not repeat after the stretch.
  - The P2 length becomes `div_q` plus the stretch cycles.
- Undefined:
  - `scl_in` is ignored and `stretching` is tied 0.
  - The timing is purely divisor-driven.

## Test plan
- Reset mid-RUN (`div`=3, assert `rst` in P2) → next cycle IDLE, `scl_out`=1, `busy`=0, no strobes.
- `div`=1, `en` held 1 → `scl_out` pattern 0,0,1,1 repeating, `ref_out` pattern 0,1,1,0, each strobe once per 4 cycles.
- `div`=5 → P0..P3 each 5 cycles, period 20. Change `div` to 2 during P1 → current period still 20 cycles, next period 8.
- `div`=0 → behaves identically to `div`=1 (4-cycle period).
- `en` dropped during P1 with `div`=4 → P1..P3 complete (cycle count verified), then IDLE, `busy`=0.
- With `I2C_SCL_STRETCH_EN`, `div`=2, `scl_in` held 0 for 7 cycles from P2 entry → P2 lasts 9 cycles, `stretching` high 7 cycles, a single `rise_stb`. Without the macro → P2 lasts 2 cycles.
